// File: rtl/bank_wbuffer_if.sv
// Bus bundle for the per-bank write data buffer.
// master: xbar/ISU/SRAM-controller side; slave: the buffer itself.
interface bank_wbuffer_if #(
   parameter int ENTRIES = 8,
   parameter int CNTW    = $clog2(ENTRIES + 1)
);
   logic            xbar_wbuf_valid_i;
   logic            xbar_wbuf_ready_o;
   logic [127:0]    xbar_wbuf_data_i;
   logic [7:0]      wbuf_xbar_id_o;
   logic            sc_wbuf_req_valid_i;
   logic [7:0]      sc_wbuf_req_wbuffer_id_i;
   logic            sc_wbuf_rtn_valid_o;
   logic [127:0]    sc_wbuf_rtn_data_o;
   logic [CNTW-1:0] wbuf_cnt_o;
   logic            wbuf_err_o;

   modport master (
      output xbar_wbuf_valid_i, xbar_wbuf_data_i,
      output sc_wbuf_req_valid_i, sc_wbuf_req_wbuffer_id_i,
      input  xbar_wbuf_ready_o, wbuf_xbar_id_o,
      input  sc_wbuf_rtn_valid_o, sc_wbuf_rtn_data_o,
      input  wbuf_cnt_o, wbuf_err_o
   );

   modport slave (
      input  xbar_wbuf_valid_i, xbar_wbuf_data_i,
      input  sc_wbuf_req_valid_i, sc_wbuf_req_wbuffer_id_i,
      output xbar_wbuf_ready_o, wbuf_xbar_id_o,
      output sc_wbuf_rtn_valid_o, sc_wbuf_rtn_data_o,
      output wbuf_cnt_o, wbuf_err_o
   );
endinterface

// File: rtl/bank_wbuffer.sv
// Per-bank write data buffer: captures xbar write data into the lowest free
// entry and hands back its ID; the SRAM controller later reads the entry by
// ID, getting the data one cycle later while the entry is released.
// Optional macro WBUF_ERR_CHECK_EN enables the sticky protocol error flag.
module bank_wbuffer #(
   parameter int ENTRIES = 8,
   parameter int CNTW    = $clog2(ENTRIES + 1)
) (
   input logic              clk_i,
   input logic              rst_i,
   bank_wbuffer_if.slave    bus
);
   localparam int IDW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid_q;
   logic [127:0]       data_q [ENTRIES];
   logic [CNTW-1:0]    cnt_q;
   logic               rtn_valid_q;
   logic [127:0]       rtn_data_q;
   logic               err_q;

   logic [IDW-1:0]     alloc_idx;
   logic               free_any;
   logic               alloc;
   logic [IDW-1:0]     req_idx;
   logic               req_in_range;
   logic               release_hit;

   // Priority encoder: the lowest free entry is the next one handed out
   always_comb begin
      alloc_idx = '0;
      free_any  = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_idx = IDW'(i);
            free_any  = 1'b1;
         end
      end
   end

   assign alloc        = bus.xbar_wbuf_valid_i & free_any;
   assign req_idx      = bus.sc_wbuf_req_wbuffer_id_i[IDW-1:0];
   assign req_in_range = ({1'b0, bus.sc_wbuf_req_wbuffer_id_i} < 9'(ENTRIES));
   assign release_hit  = bus.sc_wbuf_req_valid_i & req_in_range & valid_q[req_idx];

   // Entry occupancy: release first, then allocation, so a fresh write always lands
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         if (release_hit) valid_q[req_idx]   <= 1'b0;
         if (alloc)       valid_q[alloc_idx] <= 1'b1;
      end
   end

   // Data storage is never reset; an entry is meaningful only once written
   always_ff @(posedge clk_i) begin
      if (alloc) data_q[alloc_idx] <= bus.xbar_wbuf_data_i;
   end

   // Occupancy count tracks successful allocations minus real releases
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_q + CNTW'(alloc) - CNTW'(release_hit);
   end

   // Return path: one-cycle pulse, data held until the next request
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rtn_valid_q <= 1'b0;
         rtn_data_q  <= '0;
      end else if (bus.sc_wbuf_req_valid_i) begin
         rtn_valid_q <= 1'b1;
         rtn_data_q  <= req_in_range ? data_q[req_idx] : 128'd0;
      end else begin
         rtn_valid_q <= 1'b0;
      end
   end

`ifdef WBUF_ERR_CHECK_EN
   logic [4:0] stall_cnt;
   logic       stalled;
   logic       bad_req;

   assign stalled = bus.xbar_wbuf_valid_i & ~free_any;
   assign bad_req = bus.sc_wbuf_req_valid_i & ~(req_in_range & valid_q[req_idx]);

   // Count consecutive stalled offers; any break in the stall restarts the count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)               stall_cnt <= '0;
      else if (!stalled)       stall_cnt <= '0;
      else if (stall_cnt != 5'd31) stall_cnt <= stall_cnt + 5'd1;
   end

   // Sticky error: bad request, or an offer stalled beyond sixteen cycles
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 1'b0;
      else if (bad_req || (stalled && stall_cnt >= 5'd16)) err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   assign bus.xbar_wbuf_ready_o   = free_any;
   assign bus.wbuf_xbar_id_o      = 8'(alloc_idx);
   assign bus.sc_wbuf_rtn_valid_o = rtn_valid_q;
   assign bus.sc_wbuf_rtn_data_o  = rtn_data_q;
   assign bus.wbuf_cnt_o          = cnt_q;
   assign bus.wbuf_err_o          = err_q;
endmodule

// File: tb/tb_bank_wbuffer.sv
// Self-checking bench for bank_wbuffer: directed scenarios plus random
// traffic, compared each cycle against a set/queue-level model of the buffer.
module tb_bank_wbuffer;
   localparam int ENTRIES = 8;
`ifdef WBUF_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   cmp_en   = 1'b0;

   bank_wbuffer_if #(.ENTRIES(ENTRIES)) bus ();

   bank_wbuffer #(.ENTRIES(ENTRIES)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   bit           m_valid [ENTRIES];
   bit           m_known [ENTRIES];
   logic [127:0] m_data  [ENTRIES];
   bit           m_rtn_valid;
   logic [127:0] m_rtn_data;
   bit           m_rtn_known;
   bit           m_err;
   int           m_stall;

   function automatic int firstFree();
      for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   function automatic int countValid();
      int n = 0;
      for (int i = 0; i < ENTRIES; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: decisions use the state as it was before this edge
   always @(posedge clk_i or posedge rst_i) begin : model_blk
      int ff;
      int rid;
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
         m_rtn_valid = 1'b0;
         m_rtn_data  = '0;
         m_rtn_known = 1'b1;
         m_err       = 1'b0;
         m_stall     = 0;
      end else begin
         ff  = firstFree();
         rid = int'(bus.sc_wbuf_req_wbuffer_id_i);
         if (ERR_EN) begin
            if (bus.sc_wbuf_req_valid_i && (rid >= ENTRIES || !m_valid[rid])) m_err = 1'b1;
            if (bus.xbar_wbuf_valid_i && ff < 0) begin
               if (m_stall >= 16) m_err = 1'b1;
               m_stall++;
            end else begin
               m_stall = 0;
            end
         end
         m_rtn_valid = bus.sc_wbuf_req_valid_i;
         if (bus.sc_wbuf_req_valid_i) begin
            if (rid >= ENTRIES) begin
               m_rtn_data  = '0;
               m_rtn_known = 1'b1;
            end else begin
               m_rtn_data  = m_data[rid];
               m_rtn_known = m_known[rid];
               m_valid[rid] = 1'b0;
            end
         end
         if (bus.xbar_wbuf_valid_i && ff >= 0) begin
            m_valid[ff] = 1'b1;
            m_known[ff] = 1'b1;
            m_data[ff]  = bus.xbar_wbuf_data_i;
         end
      end
   end

   // Per-cycle comparison of every registered output against the model
   always @(negedge clk_i) begin : cmp_blk
      int ff;
      if (cmp_en && !rst_i) begin
         ff = firstFree();
         checkOutput("ready", 128'(bus.xbar_wbuf_ready_o), 128'(ff >= 0));
         if (ff >= 0) checkOutput("alloc_id", 128'(bus.wbuf_xbar_id_o), 128'(ff));
         checkOutput("cnt", 128'(bus.wbuf_cnt_o), 128'(countValid()));
         checkOutput("rtn_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'(m_rtn_valid));
         if (m_rtn_known) checkOutput("rtn_data", bus.sc_wbuf_rtn_data_o, m_rtn_data);
         checkOutput("err", 128'(bus.wbuf_err_o), 128'(m_err));
      end
   end

   // Drive one cycle of inputs (called at posedge+2), capture the handshake ID
   task automatic applyStimulus(input bit wv, input logic [127:0] wd, input bit rv,
                                input logic [7:0] rid, output logic [7:0] id_seen);
      bus.xbar_wbuf_valid_i        = wv;
      bus.xbar_wbuf_data_i         = wd;
      bus.sc_wbuf_req_valid_i      = rv;
      bus.sc_wbuf_req_wbuffer_id_i = rid;
      #1 id_seen = bus.wbuf_xbar_id_o;
      @(posedge clk_i);
      #2;
   endtask

   logic [7:0] id_seen;

   // Directed scenarios, random traffic, then asynchronous reset
   initial begin
      bus.xbar_wbuf_valid_i        = 1'b0;
      bus.xbar_wbuf_data_i         = '0;
      bus.sc_wbuf_req_valid_i      = 1'b0;
      bus.sc_wbuf_req_wbuffer_id_i = '0;
      #1;
      checkOutput("reset_ready", 128'(bus.xbar_wbuf_ready_o), 128'd1);
      checkOutput("reset_cnt", 128'(bus.wbuf_cnt_o), 128'd0);
      checkOutput("reset_rtn_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd0);
      checkOutput("reset_rtn_data", bus.sc_wbuf_rtn_data_o, 128'd0);
      checkOutput("reset_err", 128'(bus.wbuf_err_o), 128'd0);
      checkOutput("reset_id", 128'(bus.wbuf_xbar_id_o), 128'd0);
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      cmp_en = 1'b1;

      // Request to an empty entry
      applyStimulus(1'b0, '0, 1'b1, 8'd3, id_seen);
      checkOutput("empty_rtn_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd1);
      checkOutput("empty_cnt", 128'(bus.wbuf_cnt_o), 128'd0);
      checkOutput("empty_err", 128'(bus.wbuf_err_o), 128'(ERR_EN));

      // Allocation order
      applyStimulus(1'b1, 128'hA, 1'b0, 8'd0, id_seen);
      checkOutput("alloc_a_id", 128'(id_seen), 128'd0);
      applyStimulus(1'b1, 128'hB, 1'b0, 8'd0, id_seen);
      checkOutput("alloc_b_id", 128'(id_seen), 128'd1);
      applyStimulus(1'b1, 128'hC, 1'b0, 8'd0, id_seen);
      checkOutput("alloc_c_id", 128'(id_seen), 128'd2);
      checkOutput("alloc_cnt", 128'(bus.wbuf_cnt_o), 128'd3);

      // Return latency and reuse of the lowest free ID
      applyStimulus(1'b0, '0, 1'b1, 8'd1, id_seen);
      checkOutput("rtn1_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd1);
      checkOutput("rtn1_data", bus.sc_wbuf_rtn_data_o, 128'hB);
      checkOutput("rtn1_cnt", 128'(bus.wbuf_cnt_o), 128'd2);
      applyStimulus(1'b1, 128'hD, 1'b0, 8'd0, id_seen);
      checkOutput("reuse_id", 128'(id_seen), 128'd1);
      checkOutput("hold_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd0);
      checkOutput("hold_data", bus.sc_wbuf_rtn_data_o, 128'hB);

      // Fill to full
      for (int i = 3; i < ENTRIES; i++) begin
         applyStimulus(1'b1, 128'(32'h100 + i), 1'b0, 8'd0, id_seen);
         checkOutput("fill_id", 128'(id_seen), 128'(i));
      end
      checkOutput("full_ready", 128'(bus.xbar_wbuf_ready_o), 128'd0);
      checkOutput("full_cnt", 128'(bus.wbuf_cnt_o), 128'd8);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 128'hFF, 1'b0, 8'd0, id_seen);
      checkOutput("full_hold_cnt", 128'(bus.wbuf_cnt_o), 128'd8);
      applyStimulus(1'b1, 128'hFF, 1'b1, 8'd5, id_seen);
      checkOutput("full_rel_ready", 128'(bus.xbar_wbuf_ready_o), 128'd1);
      checkOutput("full_rel_data", bus.sc_wbuf_rtn_data_o, 128'h105);
      applyStimulus(1'b1, 128'hFF, 1'b0, 8'd0, id_seen);
      checkOutput("full_next_id", 128'(id_seen), 128'd5);

      // Drain to four entries, then simultaneous write and release of ID 0
      for (int i = ENTRIES - 1; i >= 4; i--) applyStimulus(1'b0, '0, 1'b1, 8'(i), id_seen);
      checkOutput("drain_cnt", 128'(bus.wbuf_cnt_o), 128'd4);
      applyStimulus(1'b1, 128'hEE, 1'b1, 8'd0, id_seen);
      checkOutput("simul_id", 128'(id_seen), 128'd4);
      checkOutput("simul_cnt", 128'(bus.wbuf_cnt_o), 128'd4);
      checkOutput("simul_data", bus.sc_wbuf_rtn_data_o, 128'hA);

      // Out-of-range request
      applyStimulus(1'b0, '0, 1'b1, 8'd9, id_seen);
      checkOutput("oor_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd1);
      checkOutput("oor_data", bus.sc_wbuf_rtn_data_o, 128'd0);
      checkOutput("oor_cnt", 128'(bus.wbuf_cnt_o), 128'd4);
      checkOutput("oor_err", 128'(bus.wbuf_err_o), 128'(ERR_EN));

      // Random traffic checked by the compare process
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 9) < 6), {$urandom, $urandom, $urandom, $urandom},
                       ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 9)), id_seen);
      end

      // Asynchronous reset during a return with five entries held
      applyStimulus(1'b0, '0, 1'b0, 8'd0, id_seen);
      rst_i = 1'b1;
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 128'(32'h200 + i), 1'b0, 8'd0, id_seen);
      checkOutput("pre_rst_cnt", 128'(bus.wbuf_cnt_o), 128'd5);
      applyStimulus(1'b0, '0, 1'b1, 8'd2, id_seen);
      checkOutput("pre_rst_rtn_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd1);
      bus.sc_wbuf_req_valid_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      checkOutput("arst_ready", 128'(bus.xbar_wbuf_ready_o), 128'd1);
      checkOutput("arst_cnt", 128'(bus.wbuf_cnt_o), 128'd0);
      checkOutput("arst_rtn_valid", 128'(bus.sc_wbuf_rtn_valid_o), 128'd0);
      checkOutput("arst_err", 128'(bus.wbuf_err_o), 128'd0);
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 8'd0, id_seen);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bank_wbuffer.md
Name: bank_wbuffer

Overview:
- Per-bank write data buffer that sits directly upstream of the bank SRAM controller's write path.
- Captures 128-bit write data from the xbar and allocates an entry ID for it; the ISU forwards that ID with the WRITE op.
- When the SRAM controller requests an ID, the buffer returns the data one cycle later and frees the entry.

Parameters:
- ENTRIES, 8, number of buffer entries (2..256); entry IDs are 0..ENTRIES-1.
- CNTW, $clog2(ENTRIES+1), width of the occupancy count.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset: asynchronous, active-high.
- xbar_wbuf_valid_i  input  1  write data offered.
- xbar_wbuf_ready_o  output  1  a free entry exists.
- xbar_wbuf_data_i  input  128  write data.
- wbuf_xbar_id_o  output  8  ID allocated on this cycle's handshake; zero-extended.
- sc_wbuf_req_valid_i  input  1  read-and-release request.
- sc_wbuf_req_wbuffer_id_i  input  8  entry to read.
- sc_wbuf_rtn_valid_o  output  1  return data valid (pulse).
- sc_wbuf_rtn_data_o  output  128  returned data.
- wbuf_cnt_o  output  CNTW  occupied-entry count.
- wbuf_err_o  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- State:
  - valid_Q[ENTRIES], reset 0.
  - data_Q[ENTRIES][128], no reset.
  - cnt_Q, reset 0.
  - rtn_valid_Q, reset 0.
  - rtn_data_Q, reset 0.
  - err_Q, reset 0.
- Reset values of outputs:
  - ready = 1 (all entries free).
  - rtn_valid = 0, rtn_data = 0, cnt = 0, err = 0.
  - wbuf_xbar_id_o = 0.
- Allocation:
  - free_vec = ~valid_Q.
  - alloc_id = lowest index set in free_vec.
  - xbar_wbuf_ready_o = |free_vec.
  - wbuf_xbar_id_o = alloc_id, combinational, valid in the handshake cycle.
  - On valid&ready: valid_Q[alloc_id] <= 1 and data_Q[alloc_id] <= data at the clock edge.
- Ready does not depend on xbar_wbuf_valid_i.
- A release in the same cycle does not raise ready; the freed entry becomes allocatable the next cycle.
- Request/return:
  - On sc_wbuf_req_valid_i: rtn_valid_Q <= 1 and rtn_data_Q <= data_Q[id]; else rtn_valid_Q <= 0.
  - Latency is exactly 1 cycle, with no backpressure.
  - valid_Q[id] <= 0 at the same edge (release).
  - rtn_data_o holds its value until the next request.
- Write-then-request, same cycle, same ID: impossible, because the ID is not yet known to the ISU. No bypass path is required.
- Occupancy:
  - cnt_Q <= cnt_Q + alloc - release, with release counted only if the target entry was valid.
  - Simultaneous alloc and release leaves cnt unchanged.
  - cnt never exceeds ENTRIES and never underflows.
- Full: ready=0; xbar valid held high is ignored (no state change).
- Empty: a request to an invalid entry returns stale data_Q[id] with rtn_valid=1 and does not change cnt.
- ID out of range (id >= ENTRIES): rtn_data = 0, rtn_valid = 1, no state change.
- Reset mid-operation: all entries freed and a pending rtn_valid is dropped.

Optional Feature:
- Macro: WBUF_ERR_CHECK_EN.
- Defined:
  - err_Q sets on sc_wbuf_req_valid_i with id >= ENTRIES or valid_Q[id]==0.
  - Also sets on xbar_wbuf_valid_i while ready=0 for more than 16 consecutive cycles (5-bit stall counter, cleared on ready).
  - err_Q is sticky until reset and drives wbuf_err_o.
- Undefined: wbuf_err_o tied 0; no stall counter or checking logic.

Test Plan:
- Allocation order: 3 back-to-back writes 0xA, 0xB, 0xC -> IDs 0,1,2 in the handshake cycles; cnt=3.
- Return latency: request ID 1 -> rtn_valid=1 and rtn_data=0xB exactly one cycle later; cnt=2. A following write receives ID 1 (lowest free); rtn_data holds 0xB while no request.
- Full: fill 8 entries -> ready=0, cnt=8. Hold xbar valid with data 0xFF -> no entry changes. Request ID 5 -> ready=1 the cycle after the edge, and the next write gets ID 5.
- Simultaneous: write and request of ID 0 in the same cycle with cnt=4 -> cnt stays 4, rtn_data=old ID0 data, and the new write takes the lowest free index.
- Errors (WBUF_ERR_CHECK_EN defined): request ID 3 when empty -> err=1 and stays set until rst_i. Request ID 9 with ENTRIES=8 -> rtn_data=0, err=1. Macro undefined -> err=0 throughout.
- Async reset: assert rst_i mid-return with cnt=5 -> immediately ready=1, cnt=0, rtn_valid=0, err=0.
